// File: rtl/axis_packer_if.sv
// AXI-Stream bundle used on both sides of axis_packer.
// master drives tdata/tkeep/tvalid/tlast/tuser, slave drives tready.
interface axis_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/axis_packer.sv
// axis_packer: compacts sparse-tkeep narrow beats into full wide words,
// emitting a low-aligned partial word at the end of each frame.
// Ports: clk, rst (async, active high), input_axis (slave, narrow),
// output_axis (master, wide, single output register).
// Optional macro AXIS_PACKER_TIMEOUT_EN: idle flush of partial bytes.
module axis_packer #(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int INPUT_KEEP_WIDTH  = INPUT_DATA_WIDTH / 8,
  parameter int OUTPUT_DATA_WIDTH = 64,
  parameter int OUTPUT_KEEP_WIDTH = OUTPUT_DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES    = 256
) (
  input  logic         clk,
  input  logic         rst,
  axis_packer_if.slave  input_axis,
  axis_packer_if.master output_axis
);
  localparam int IKW = INPUT_KEEP_WIDTH;
  localparam int OKW = OUTPUT_KEEP_WIDTH;
  localparam int AW  = OKW + IKW - 1;
  localparam int AB  = AW * 8;
  localparam int CW  = $clog2(OKW + IKW);
  localparam int OW1 = OKW + 1;
  localparam logic [CW-1:0] OKW_C = CW'(OKW);
  localparam logic [OKW:0]  ONE   = OW1'(1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]    state, state_n;
  logic [AB-1:0] acc, acc_n;
  logic [CW-1:0] acc_cnt, cnt_n;
  logic          user_or, uor_n;

  logic [OUTPUT_DATA_WIDTH-1:0] o_data;
  logic [OKW-1:0]               o_keep;
  logic                         o_valid;
  logic                         o_last;
  logic                         o_user;

  logic          load_ok;
  logic          rdy;
  logic          accept;
  logic          tmo_fire;
  logic [IKW*8-1:0] comp;
  logic [CW-1:0] n;
  logic [CW-1:0] new_cnt;
  logic [AB-1:0] merged;
  logic [AB-1:0] rem;

  logic                         ld;
  logic [OUTPUT_DATA_WIDTH-1:0] ld_data;
  logic [OKW-1:0]               ld_keep;
  logic                         ld_last;
  logic                         ld_user;

  function automatic logic [OKW-1:0] kmask(input logic [CW-1:0] c);
    logic [OKW:0] t;
    t = (ONE << c) - ONE;
    return t[OKW-1:0];
  endfunction

  assign load_ok = !o_valid | output_axis.tready;
  assign rdy     = !rst & (state == ACCUM) & load_ok;
  assign accept  = input_axis.tvalid & rdy;

  // squeeze kept lanes down to the bottom, lane 0 first
  always_comb begin
    comp = '0;
    n    = '0;
    for (int i = 0; i < IKW; i++) begin
      if (input_axis.tkeep[i]) begin
        comp[n*8 +: 8] = input_axis.tdata[i*8 +: 8];
        n = n + CW'(1);
      end
    end
  end

  // acc bytes at or above acc_cnt are always zero, so OR merges cleanly
  assign merged  = acc | (AB'(comp) << {acc_cnt, 3'b000});
  assign new_cnt = acc_cnt + n;
  assign rem     = merged >> (OKW * 8);

  always_comb begin
    ld      = 1'b0;
    ld_data = merged[OKW*8-1:0];
    ld_keep = '0;
    ld_last = 1'b0;
    ld_user = 1'b0;
    acc_n   = acc;
    cnt_n   = acc_cnt;
    uor_n   = user_or;
    state_n = state;
    if (state == FLUSH) begin
      if (load_ok) begin
        ld      = 1'b1;
        ld_data = acc[OKW*8-1:0];
        ld_keep = kmask(acc_cnt);
        ld_last = 1'b1;
        ld_user = user_or;
        acc_n   = '0;
        cnt_n   = '0;
        uor_n   = 1'b0;
        state_n = ACCUM;
      end
    end else if (accept) begin
      if (input_axis.tlast && new_cnt <= OKW_C) begin
        ld      = 1'b1;
        ld_keep = kmask(new_cnt);
        ld_last = 1'b1;
        ld_user = user_or | input_axis.tuser;
        acc_n   = '0;
        cnt_n   = '0;
        uor_n   = 1'b0;
      end else if (new_cnt >= OKW_C) begin
        ld      = 1'b1;
        ld_keep = '1;
        acc_n   = rem;
        cnt_n   = new_cnt - OKW_C;
        uor_n   = user_or | input_axis.tuser;
        if (input_axis.tlast) state_n = FLUSH;
      end else begin
        acc_n   = merged;
        cnt_n   = new_cnt;
        uor_n   = user_or | input_axis.tuser;
      end
    end else if (tmo_fire) begin
      // partial word mid-frame; tuser OR carries on to tlast
      ld      = 1'b1;
      ld_data = acc[OKW*8-1:0];
      ld_keep = kmask(acc_cnt);
      acc_n   = '0;
      cnt_n   = '0;
    end
  end

`ifdef AXIS_PACKER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        idle;

  assign idle     = (state == ACCUM) & !accept & (acc_cnt != '0);
  assign tmo_fire = idle & load_ok &
                    (32'(tmo_cnt) + 32'd1 >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (accept | ld) begin
      tmo_cnt <= '0;
    end else if (idle && 32'(tmo_cnt) < 32'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      acc_cnt <= '0;
      user_or <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
      o_user  <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      acc_cnt <= cnt_n;
      user_or <= uor_n;
      if (ld) begin
        o_valid <= 1'b1;
        o_data  <= ld_data;
        o_keep  <= ld_keep;
        o_last  <= ld_last;
        o_user  <= ld_user;
      end else if (output_axis.tready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign input_axis.tready  = rdy;
  assign output_axis.tdata  = o_data;
  assign output_axis.tkeep  = o_keep;
  assign output_axis.tvalid = o_valid;
  assign output_axis.tlast  = o_last;
  assign output_axis.tuser  = o_user;
endmodule

// File: tb/tb_axis_packer.sv
// Self-checking bench for axis_packer, 16-bit in, 64-bit out.
// Directed vector table, hand sequences, then random frames vs a model.
module tb_axis_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

`ifdef AXIS_PACKER_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  always #5 clk = ~clk;

  axis_packer_if #(.DATA_WIDTH(16)) in_if ();
  axis_packer_if #(.DATA_WIDTH(64)) out_if ();

  axis_packer #(
    .INPUT_DATA_WIDTH(16),
    .OUTPUT_DATA_WIDTH(64),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .input_axis(in_if),
    .output_axis(out_if)
  );

  typedef struct {
    logic        v;
    logic [1:0]  k;
    logic [15:0] d;
    logic        l;
    logic        u;
    logic        ev;
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        el;
    logic        eu;
    logic        er;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } word_t;

  vec_t  tbl[20];
  word_t exp_q[$];
  logic [1:0]  bk[$];
  logic [15:0] bd[$];
  logic        bl[$];
  logic        bu[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] k,
                       input logic [15:0] d, input logic l,
                       input logic u);
    in_if.tvalid = v;
    in_if.tkeep  = k;
    in_if.tdata  = d;
    in_if.tlast  = l;
    in_if.tuser  = u;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mv(logic v, logic [1:0] k, logic [15:0] d,
                              logic l, logic u, logic ev,
                              logic [63:0] ed, logic [7:0] ek,
                              logic el, logic eu, logic er);
    vec_t r;
    r.v = v; r.k = k; r.d = d; r.l = l; r.u = u;
    r.ev = ev; r.ed = ed; r.ek = ek; r.el = el; r.eu = eu; r.er = er;
    return r;
  endfunction

  function automatic word_t mkw(input byte unsigned b[$], input int base,
                                input int cnt, input logic l,
                                input logic u);
    word_t w;
    w.d = '0;
    w.k = '0;
    for (int i = 0; i < cnt; i++) begin
      w.d[i*8 +: 8] = b[base+i];
      w.k[i] = 1'b1;
    end
    w.l = l;
    w.u = u;
    return w;
  endfunction

  // Frame model: each non-last beat crossing an 8-byte boundary gives a
  // full word; whatever the tlast beat leaves is one or two words.
  task automatic gen_frame();
    byte unsigned b[$];
    int nb;
    int lb;
    int kf;
    int r;
    logic uor;
    logic [1:0] kp;
    logic [15:0] dp;
    logic up;
    nb = $urandom_range(1, 10);
    uor = 1'b0;
    lb = 0;
    for (int k = 0; k < nb; k++) begin
      kp = 2'($urandom_range(0, 3));
      dp = 16'($urandom);
      up = ($urandom_range(0, 7) == 0);
      if (k == nb - 1) lb = b.size();
      for (int i = 0; i < 2; i++)
        if (kp[i]) b.push_back(dp[i*8 +: 8]);
      uor |= up;
      bk.push_back(kp);
      bd.push_back(dp);
      bl.push_back(k == nb - 1);
      bu.push_back(up);
    end
    kf = lb / 8;
    for (int w = 0; w < kf; w++)
      exp_q.push_back(mkw(b, w * 8, 8, 1'b0, 1'b0));
    r = b.size() - kf * 8;
    if (r <= 8) begin
      exp_q.push_back(mkw(b, kf * 8, r, 1'b1, uor));
    end else begin
      exp_q.push_back(mkw(b, kf * 8, 8, 1'b0, 1'b0));
      exp_q.push_back(mkw(b, kf * 8 + 8, r - 8, 1'b1, uor));
    end
  endtask

  initial begin
    int bi;
    int ncyc;
    int wt;
    bit vld;
    word_t w;

    drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    out_if.tready = 1'b1;

    for (int k = 0; k < 8; k++)
      tbl[k] = mv(1, 2'b11, {8'(2*k+1), 8'(2*k)}, k == 7, 0,
                  k == 3 || k == 7,
                  k == 3 ? 64'h0706050403020100 : 64'h0F0E0D0C0B0A0908,
                  8'hFF, k == 7, 0, 1);
    tbl[8]  = mv(1, 2'b01, 16'h000A, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mv(1, 2'b10, 16'h0B00, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mv(1, 2'b11, 16'h0D0C, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mv(1, 2'b00, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[12] = mv(1, 2'b11, 16'h0F0E, 1, 0,
                 1, 64'h00000F0E0D0C0B0A, 8'h3F, 1, 0, 1);
    tbl[13] = mv(1, 2'b11, 16'h1110, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = mv(1, 2'b11, 16'h1312, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[15] = mv(1, 2'b11, 16'h1514, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[16] = mv(1, 2'b01, 16'hAA16, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[17] = mv(1, 2'b11, 16'h1817, 1, 0,
                 1, 64'h1716151413121110, 8'hFF, 0, 0, 0);
    tbl[18] = mv(0, 2'b00, 16'h0000, 0, 0,
                 1, 64'h18, 8'h01, 1, 1, 1);
    tbl[19] = mv(1, 2'b00, 16'h1234, 1, 0,
                 1, 64'h0, 8'h00, 1, 0, 1);

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ovalid", out_if.tvalid, 0);
    chk("rst_odata", out_if.tdata, 0);
    chk("rst_okeep", out_if.tkeep, 0);
    chk("rst_olast", out_if.tlast, 0);
    chk("rst_ouser", out_if.tuser, 0);
    chk("rst_iready", in_if.tready, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_iready", in_if.tready, 1);

    // table vectors
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].k, tbl[i].d, tbl[i].l, tbl[i].u);
      cyc();
      chk($sformatf("t%0d_valid", i), out_if.tvalid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("t%0d_data", i), out_if.tdata, tbl[i].ed);
        chk($sformatf("t%0d_keep", i), out_if.tkeep, tbl[i].ek);
        chk($sformatf("t%0d_last", i), out_if.tlast, tbl[i].el);
        chk($sformatf("t%0d_user", i), out_if.tuser, tbl[i].eu);
      end
      chk($sformatf("t%0d_iready", i), in_if.tready, tbl[i].er);
    end
    drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    cyc();

    // null frame under backpressure
    out_if.tready = 1'b0;
    drive(1'b1, 2'b00, 16'hBEEF, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", out_if.tvalid, 1);
      chk("bp_keep", out_if.tkeep, 0);
      chk("bp_last", out_if.tlast, 1);
      chk("bp_iready", in_if.tready, 0);
      cyc();
    end
    out_if.tready = 1'b1;
    #1;
    chk("bp_release_iready", in_if.tready, 1);
    cyc();
    chk("bp_drained", out_if.tvalid, 0);

    // async reset with 3 bytes held
    drive(1'b1, 2'b11, 16'hE1E0, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 2'b01, 16'h77E2, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    chk("pre_rst_iready", in_if.tready, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_iready", in_if.tready, 0);
    chk("arst_valid", out_if.tvalid, 0);
    chk("arst_data", out_if.tdata, 0);
    chk("arst_keep", out_if.tkeep, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'b11, 16'h2120, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 2'b11, 16'h2322, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    chk("after_rst_valid", out_if.tvalid, 1);
    chk("after_rst_data", out_if.tdata, 64'h23222120);
    chk("after_rst_keep", out_if.tkeep, 8'h0F);
    chk("after_rst_last", out_if.tlast, 1);
    chk("after_rst_user", out_if.tuser, 0);
    cyc();

`ifdef AXIS_PACKER_TIMEOUT_EN
    // idle flush of 3 held bytes
    drive(1'b1, 2'b11, 16'h3130, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 2'b01, 16'h0032, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    wt = 0;
    while (!out_if.tvalid && wt < 12) begin
      cyc();
      wt++;
    end
    chk("tmo_seen", out_if.tvalid, 1);
    chk("tmo_delay_ok", (wt >= 3 && wt <= 6), 1);
    chk("tmo_keep", out_if.tkeep, 8'h07);
    chk("tmo_data", out_if.tdata, 64'h323130);
    chk("tmo_last", out_if.tlast, 0);
    chk("tmo_user", out_if.tuser, 0);
    drive(1'b1, 2'b01, 16'h0033, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    chk("tmo_tail_data", out_if.tdata, 64'h33);
    chk("tmo_tail_keep", out_if.tkeep, 8'h01);
    chk("tmo_tail_last", out_if.tlast, 1);
    chk("tmo_tail_user", out_if.tuser, 1);
    cyc();
`endif

    // random frames against the model
    for (int f = 0; f < 40; f++) gen_frame();
    bi = 0;
    vld = 1'b0;
    ncyc = 0;
    while ((bi < bk.size() || exp_q.size() > 0) && ncyc < 20000) begin
      @(negedge clk);
      ncyc++;
      if (!vld && bi < bk.size() && (TMO || $urandom_range(0, 3) != 0))
        vld = 1'b1;
      if (vld)
        drive(1'b1, bk[bi], bd[bi], bl[bi], bu[bi]);
      else
        drive(1'b0, 2'($urandom), 16'($urandom), 1'b0, 1'b0);
      out_if.tready = TMO ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rand_extra: got word %h, none expected",
                   out_if.tdata);
        end else begin
          w = exp_q.pop_front();
          chk("rand_data", out_if.tdata, w.d);
          chk("rand_keep", out_if.tkeep, w.k);
          chk("rand_last", out_if.tlast, w.l);
          chk("rand_user", out_if.tuser, w.u);
        end
      end
      if (in_if.tvalid && in_if.tready) begin
        vld = 1'b0;
        bi++;
      end
      @(posedge clk);
    end
    chk("rand_left_words", exp_q.size(), 0);
    chk("rand_beats_taken", bi, bk.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
